// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer handing out tags (index+1) and broadcasting commits/flushes.
// Optional ROB_WB_BYPASS_EN forwards a same-cycle writeback onto the operand query ports.
module reorder_buffer #(
  parameter int ROB_SIZE = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        issue_valid,
  input  logic [1:0]  issue_dest_type,
  input  logic [4:0]  issue_rd,
  input  logic        issue_pred_taken,
  output logic [4:0]  issue_tag,
  output logic        rob_full,
  input  logic [4:0]  query1_tag,
  input  logic [4:0]  query2_tag,
  output logic        query1_ready,
  output logic        query2_ready,
  output logic [31:0] query1_value,
  output logic [31:0] query2_value,
  input  logic        wb_valid,
  input  logic [4:0]  wb_tag,
  input  logic [31:0] wb_value,
  input  logic        wb_taken,
  input  logic [31:0] wb_target,
  output logic        commit_valid,
  output logic [4:0]  commit_tag,
  output logic [1:0]  commit_dest_type,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_value,
  output logic        flush_out,
  output logic [31:0] flush_pc
);
  typedef enum logic [1:0] {EMPTY, BUSY, READY} st_e;
  localparam int PW = $clog2(ROB_SIZE);
  localparam logic [4:0] SZ = 5'(ROB_SIZE);
  localparam logic [PW-1:0] LAST = PW'(ROB_SIZE - 1);

  st_e         st_q   [ROB_SIZE], st_d   [ROB_SIZE];
  logic [1:0]  typ_q  [ROB_SIZE], typ_d  [ROB_SIZE];
  logic [4:0]  rd_q   [ROB_SIZE], rd_d   [ROB_SIZE];
  logic        pred_q [ROB_SIZE], pred_d [ROB_SIZE];
  logic        tkn_q  [ROB_SIZE], tkn_d  [ROB_SIZE];
  logic [31:0] val_q  [ROB_SIZE], val_d  [ROB_SIZE];
  logic [31:0] tgt_q  [ROB_SIZE], tgt_d  [ROB_SIZE];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        commit_valid_q, commit_valid_d, flush_out_q, flush_out_d;
  logic [4:0]  commit_tag_q, commit_tag_d, commit_rd_q, commit_rd_d;
  logic [1:0]  commit_dest_type_q, commit_dest_type_d;
  logic [31:0] commit_value_q, commit_value_d, flush_pc_q, flush_pc_d;
  logic [PW-1:0] wb_idx, q1_idx, q2_idx;
  logic        do_issue, do_wb, do_commit, mispred, q1_ok, q2_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction

  assign issue_tag        = 5'(tail_q) + 5'd1;
  assign rob_full         = cnt_q == SZ;
  assign commit_valid     = commit_valid_q;
  assign commit_tag       = commit_tag_q;
  assign commit_dest_type = commit_dest_type_q;
  assign commit_rd        = commit_rd_q;
  assign commit_value     = commit_value_q;
  assign flush_out        = flush_out_q;
  assign flush_pc         = flush_pc_q;

  always_comb begin
    q1_idx = PW'(query1_tag - 5'd1);
    q2_idx = PW'(query2_tag - 5'd1);
    q1_ok  = query1_tag != 5'd0 && query1_tag <= SZ;
    q2_ok  = query2_tag != 5'd0 && query2_tag <= SZ;
`ifdef ROB_WB_BYPASS_EN
    query1_ready = q1_ok && (st_q[q1_idx] == READY || (st_q[q1_idx] == BUSY && wb_valid && wb_tag == query1_tag));
    query2_ready = q2_ok && (st_q[q2_idx] == READY || (st_q[q2_idx] == BUSY && wb_valid && wb_tag == query2_tag));
    query1_value = (st_q[q1_idx] == BUSY && wb_valid && wb_tag == query1_tag) ? wb_value : val_q[q1_idx];
    query2_value = (st_q[q2_idx] == BUSY && wb_valid && wb_tag == query2_tag) ? wb_value : val_q[q2_idx];
`else
    query1_ready = q1_ok && st_q[q1_idx] == READY;
    query2_ready = q2_ok && st_q[q2_idx] == READY;
    query1_value = val_q[q1_idx];
    query2_value = val_q[q2_idx];
`endif
  end

  always_comb begin
    st_d = st_q;
    typ_d = typ_q;
    rd_d = rd_q;
    pred_d = pred_q;
    tkn_d = tkn_q;
    val_d = val_q;
    tgt_d = tgt_q;
    head_d = head_q;
    tail_d = tail_q;
    commit_tag_d = commit_tag_q;
    commit_dest_type_d = commit_dest_type_q;
    commit_rd_d = commit_rd_q;
    commit_value_d = commit_value_q;
    flush_pc_d = flush_pc_q;
    wb_idx = PW'(wb_tag - 5'd1);
    do_issue = rdy_in && issue_valid && !rob_full;
    do_wb = rdy_in && wb_valid && wb_tag != 5'd0 && wb_tag <= SZ && st_q[wb_idx] == BUSY;
    do_commit = rdy_in && st_q[head_q] == READY;
    mispred = do_commit && (typ_q[head_q] == 2'd3 || (typ_q[head_q] == 2'd2 && tkn_q[head_q] != pred_q[head_q]));
    commit_valid_d = do_commit;
    flush_out_d = mispred;
    cnt_d = cnt_q + 5'(do_issue) - 5'(do_commit);
    if (do_wb) begin
      st_d[wb_idx] = READY;
      val_d[wb_idx] = wb_value;
      tkn_d[wb_idx] = wb_taken;
      tgt_d[wb_idx] = wb_target;
    end
    if (do_issue) begin
      st_d[tail_q] = BUSY;
      typ_d[tail_q] = issue_dest_type;
      rd_d[tail_q] = issue_rd;
      pred_d[tail_q] = issue_pred_taken;
      tail_d = nxt(tail_q);
    end
    if (do_commit) begin
      st_d[head_q] = EMPTY;
      head_d = nxt(head_q);
      commit_tag_d = 5'(head_q) + 5'd1;
      commit_dest_type_d = typ_q[head_q];
      commit_rd_d = rd_q[head_q];
      commit_value_d = val_q[head_q];
    end
    // a mispredict discards everything younger, including this edge's issue and writeback
    if (mispred) begin
      for (int i = 0; i < ROB_SIZE; i++) st_d[i] = EMPTY;
      head_d = '0;
      tail_d = '0;
      cnt_d = '0;
      flush_pc_d = tgt_q[head_q];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        st_q[i] <= EMPTY;
        typ_q[i] <= '0;
        rd_q[i] <= '0;
        pred_q[i] <= 1'b0;
        tkn_q[i] <= 1'b0;
        val_q[i] <= '0;
        tgt_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q <= '0;
      commit_dest_type_q <= '0;
      commit_rd_q <= '0;
      commit_value_q <= '0;
      flush_out_q <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      st_q <= st_d;
      typ_q <= typ_d;
      rd_q <= rd_d;
      pred_q <= pred_d;
      tkn_q <= tkn_d;
      val_q <= val_d;
      tgt_q <= tgt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q <= commit_tag_d;
      commit_dest_type_q <= commit_dest_type_d;
      commit_rd_q <= commit_rd_d;
      commit_value_q <= commit_value_d;
      flush_out_q <= flush_out_d;
      flush_pc_q <= flush_pc_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed tests of a 4-entry reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
  logic        clk_in = 0, rst_in = 0, rdy_in = 1;
  logic        issue_valid = 0, issue_pred_taken = 0, wb_valid = 0, wb_taken = 0;
  logic [1:0]  issue_dest_type = 0;
  logic [4:0]  issue_rd = 0, query1_tag = 0, query2_tag = 0, wb_tag = 0;
  logic [31:0] wb_value = 0, wb_target = 0;
  logic [4:0]  issue_tag, commit_tag, commit_rd;
  logic        rob_full, query1_ready, query2_ready, commit_valid, flush_out;
  logic [31:0] query1_value, query2_value, commit_value, flush_pc;
  logic [1:0]  commit_dest_type;
  int n_cmp = 0, n_fail = 0;

  reorder_buffer #(.ROB_SIZE(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_dest_type(issue_dest_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_tag(issue_tag), .rob_full(rob_full),
    .query1_tag(query1_tag), .query2_tag(query2_tag), .query1_ready(query1_ready),
    .query2_ready(query2_ready), .query1_value(query1_value), .query2_value(query2_value),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
    .wb_target(wb_target), .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_dest_type(commit_dest_type), .commit_rd(commit_rd), .commit_value(commit_value),
    .flush_out(flush_out), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic p);
    issue_valid = 1; issue_dest_type = t; issue_rd = rd; issue_pred_taken = p;
    tick();
    issue_valid = 0;
  endtask

  task automatic wb(input logic [4:0] tag, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    wb_valid = 1; wb_tag = tag; wb_value = v; wb_taken = tk; wb_target = tg;
    tick();
    wb_valid = 0;
  endtask

  task automatic do_reset;
    issue_valid = 0; wb_valid = 0; rdy_in = 1;
    rst_in = 0;
    tick();
    rst_in = 1;
    tick();
  endtask

  task automatic test_reset;
    rst_in = 0; query1_tag = 1;
    #2;
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid: got %0b want 0", commit_valid); end
    n_cmp++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL reset_flush_out: got %0b want 0", flush_out); end
    n_cmp++; if (commit_tag !== 5'd0 || commit_value !== 32'd0 || flush_pc !== 32'd0) begin n_fail++; $display("FAIL reset_fields: tag %0d value %0h pc %0h want 0", commit_tag, commit_value, flush_pc); end
    n_cmp++; if (issue_tag !== 5'd1) begin n_fail++; $display("FAIL reset_issue_tag: got %0d want 1", issue_tag); end
    n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_rob_full: got %0b want 0", rob_full); end
    n_cmp++; if (query1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_query_ready: got %0b want 0", query1_ready); end
    tick();
    rst_in = 1;
    tick();
  endtask

  task automatic test_rdy;
    rdy_in = 0; issue_valid = 1; issue_dest_type = 1;
    tick();
    n_cmp++; if (issue_tag !== 5'd1) begin n_fail++; $display("FAIL rdy_freeze: issue_tag %0d want 1", issue_tag); end
    rdy_in = 1;
    tick();
    issue_valid = 0;
    n_cmp++; if (issue_tag !== 5'd2) begin n_fail++; $display("FAIL rdy_resume: issue_tag %0d want 2", issue_tag); end
    do_reset();
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (issue_tag !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_tag: got %0d want %0d", issue_tag, i + 1); end
      issue(2'd1, 5'(i + 1), 1'b0);
    end
    n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b want 1", rob_full); end
    issue(2'd1, 5'd9, 1'b0);
    n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL fill_drop: rob_full %0b want 1", rob_full); end
    for (int k = 4; k >= 1; k--) begin
      wb(5'(k), 32'h40 + k, 1'b0, 32'd0);
      n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL drain_early_commit: after wb %0d commit_valid %0b want 0", k, commit_valid); end
      if (k == 4) begin
        query1_tag = 4; query2_tag = 3; #1;
        n_cmp++; if (query1_ready !== 1'b1 || query1_value !== 32'h44) begin n_fail++; $display("FAIL query_ready: rdy %0b val %0h want 1 44", query1_ready, query1_value); end
        n_cmp++; if (query2_ready !== 1'b0) begin n_fail++; $display("FAIL query_busy: rdy %0b want 0", query2_ready); end
      end
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (commit_valid !== 1'b1 || commit_tag !== 5'(k)) begin n_fail++; $display("FAIL drain_commit: valid %0b tag %0d want 1 %0d", commit_valid, commit_tag, k); end
      n_cmp++; if (commit_rd !== 5'(k) || commit_value !== 32'h40 + k || commit_dest_type !== 2'd1) begin n_fail++; $display("FAIL drain_fields: rd %0d val %0h type %0d want %0d %0h 1", commit_rd, commit_value, commit_dest_type, k, 32'h40 + k); end
      n_cmp++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL drain_flush: got %0b want 0", flush_out); end
    end
    tick();
    n_cmp++; if (commit_valid !== 1'b0 || rob_full !== 1'b0 || issue_tag !== 5'd1) begin n_fail++; $display("FAIL drain_end: valid %0b full %0b tag %0d want 0 0 1", commit_valid, rob_full, issue_tag); end
    do_reset();
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (issue_tag !== 5'((i % 4) + 1)) begin n_fail++; $display("FAIL wrap_tag: got %0d want %0d", issue_tag, (i % 4) + 1); end
      issue(2'd1, 5'(i), 1'b0);
      wb(5'((i % 4) + 1), 32'h1000 + i, 1'b0, 32'd0);
      n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_early: commit_valid %0b want 0", commit_valid); end
      tick();
      n_cmp++; if (commit_valid !== 1'b1 || commit_tag !== 5'((i % 4) + 1) || commit_value !== 32'h1000 + i) begin n_fail++; $display("FAIL wrap_commit: valid %0b tag %0d val %0h want 1 %0d %0h", commit_valid, commit_tag, commit_value, (i % 4) + 1, 32'h1000 + i); end
    end
    do_reset();
  endtask

  task automatic test_mispredict;
    issue(2'd2, 5'd0, 1'b0);
    issue(2'd1, 5'd5, 1'b0);
    issue(2'd1, 5'd6, 1'b0);
    wb(5'd1, 32'd0, 1'b1, 32'h100);
    n_cmp++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL mp_early: flush_out %0b want 0", flush_out); end
    tick();
    n_cmp++; if (commit_valid !== 1'b1 || flush_out !== 1'b1 || flush_pc !== 32'h100) begin n_fail++; $display("FAIL mp_flush: valid %0b flush %0b pc %0h want 1 1 100", commit_valid, flush_out, flush_pc); end
    n_cmp++; if (commit_tag !== 5'd1 || commit_dest_type !== 2'd2) begin n_fail++; $display("FAIL mp_fields: tag %0d type %0d want 1 2", commit_tag, commit_dest_type); end
    n_cmp++; if (issue_tag !== 5'd1 || rob_full !== 1'b0) begin n_fail++; $display("FAIL mp_cleared: tag %0d full %0b want 1 0", issue_tag, rob_full); end
    wb(5'd2, 32'h55, 1'b0, 32'd0);
    query1_tag = 2; #1;
    n_cmp++; if (query1_ready !== 1'b0 || flush_out !== 1'b0) begin n_fail++; $display("FAIL mp_discard: ready %0b flush %0b want 0 0", query1_ready, flush_out); end
    tick();
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL mp_no_commit: valid %0b want 0", commit_valid); end
    issue(2'd3, 5'd1, 1'b0);
    wb(5'd1, 32'h44, 1'b0, 32'h200);
    tick();
    n_cmp++; if (flush_out !== 1'b1 || flush_pc !== 32'h200 || commit_dest_type !== 2'd3 || commit_value !== 32'h44) begin n_fail++; $display("FAIL jl_flush: flush %0b pc %0h type %0d val %0h want 1 200 3 44", flush_out, flush_pc, commit_dest_type, commit_value); end
    tick();
    n_cmp++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL jl_pulse: flush %0b want 0", flush_out); end
    issue(2'd2, 5'd0, 1'b1);
    wb(5'd1, 32'd0, 1'b1, 32'h300);
    tick();
    n_cmp++; if (commit_valid !== 1'b1 || flush_out !== 1'b0 || issue_tag !== 5'd2) begin n_fail++; $display("FAIL br_correct: valid %0b flush %0b tag %0d want 1 0 2", commit_valid, flush_out, issue_tag); end
    do_reset();
  endtask

  task automatic test_full_simul;
    for (int i = 0; i < 4; i++) issue(2'd1, 5'(i), 1'b0);
    wb(5'd1, 32'h11, 1'b0, 32'd0);
    issue_valid = 1; issue_dest_type = 1; issue_rd = 5'd20;
    tick();
    n_cmp++; if (commit_valid !== 1'b1 || commit_tag !== 5'd1) begin n_fail++; $display("FAIL simul_commit: valid %0b tag %0d want 1 1", commit_valid, commit_tag); end
    n_cmp++; if (issue_tag !== 5'd1 || rob_full !== 1'b0) begin n_fail++; $display("FAIL simul_reject: tag %0d full %0b want 1 0", issue_tag, rob_full); end
    tick();
    issue_valid = 0;
    n_cmp++; if (issue_tag !== 5'd2 || rob_full !== 1'b1 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL simul_accept: tag %0d full %0b valid %0b want 2 1 0", issue_tag, rob_full, commit_valid); end
    do_reset();
  endtask

  task automatic test_bypass;
    issue(2'd1, 5'd1, 1'b0);
    issue(2'd1, 5'd2, 1'b0);
    query1_tag = 2; wb_valid = 1; wb_tag = 2; wb_value = 32'hDEAD; wb_taken = 0; wb_target = 0;
    #1;
`ifdef ROB_WB_BYPASS_EN
    n_cmp++; if (query1_ready !== 1'b1 || query1_value !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_same: ready %0b val %0h want 1 dead", query1_ready, query1_value); end
`else
    n_cmp++; if (query1_ready !== 1'b0) begin n_fail++; $display("FAIL bypass_same: ready %0b want 0", query1_ready); end
`endif
    tick();
    wb_valid = 0;
    #1;
    n_cmp++; if (query1_ready !== 1'b1 || query1_value !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_next: ready %0b val %0h want 1 dead", query1_ready, query1_value); end
    do_reset();
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) issue(2'd1, 5'(i + 1), 1'b0);
    wb(5'd1, 32'h77, 1'b0, 32'd0);
    tick();
    n_cmp++; if (commit_valid !== 1'b1 || commit_value !== 32'h77) begin n_fail++; $display("FAIL rm_setup: valid %0b val %0h want 1 77", commit_valid, commit_value); end
    issue(2'd1, 5'd7, 1'b0);
    wb(5'd2, 32'h88, 1'b0, 32'd0);
    n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL rm_full: got %0b want 1", rob_full); end
    #2;
    rst_in = 0; query1_tag = 2;
    #1;
    n_cmp++; if (commit_tag !== 5'd0 || commit_value !== 32'd0 || commit_rd !== 5'd0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL rm_outputs: tag %0d val %0h rd %0d valid %0b want 0", commit_tag, commit_value, commit_rd, commit_valid); end
    n_cmp++; if (rob_full !== 1'b0 || issue_tag !== 5'd1 || query1_ready !== 1'b0) begin n_fail++; $display("FAIL rm_state: full %0b tag %0d ready %0b want 0 1 0", rob_full, issue_tag, query1_ready); end
    tick();
    rst_in = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_commit: valid %0b want 0", commit_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rdy();
    test_fill_drain();
    test_wrap();
    test_mispredict();
    test_full_simul();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the Tomasulo core. It allocates a tag per decoded instruction, hands that tag to the reservation station as the destination entry, and collects execution results. It retires entries in program order and broadcasts each retirement on the commit bus that the reservation station and register file snoop. Tags are `index+1`, so tag 0 keeps its codebase meaning of "no dependency / value ready".

## Interface
Parameters:
- `ROB_SIZE`, default 16: number of entries; legal range 2..31 (tags are 5 bits).

Ports:
- `clk_in` in 1: single clock; all state updates on its rising edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global enable; low freezes all state.
- `issue_valid` in 1: decoder presents an instruction.
- `issue_dest_type` in 2: 0 mem, 1 reg, 2 branch, 3 jl.
- `issue_rd` in 5: architectural destination register.
- `issue_pred_taken` in 1: branch prediction made at fetch.
- `issue_tag` out 5: tag allocated to the current issue; combinational, equals `tail+1`.
- `rob_full` out 1: combinational, `count == ROB_SIZE`.
- `query1_tag`, `query2_tag` in 5: operand tags looked up by the decoder.
- `query1_ready`, `query2_ready` out 1: the queried entry holds its result (combinational).
- `query1_value`, `query2_value` out 32: the stored result.
- `wb_valid` in 1: an execution unit returns a result.
- `wb_tag` in 5: tag of the returning instruction.
- `wb_value` in 32: result value.
- `wb_taken` in 1: actual branch outcome.
- `wb_target` in 32: correct next PC for a branch or jl.
- `commit_valid` out 1: registered one-cycle retirement pulse.
- `commit_tag` out 5: tag of the retiring entry.
- `commit_dest_type` out 2: destination type of the retiring entry.
- `commit_rd` out 5: destination register of the retiring entry.
- `commit_value` out 32: result of the retiring entry.
- `flush_out` out 1: registered one-cycle mispredict pulse.
- `flush_pc` out 32: redirect target.

## Operation
- Per-entry state: EMPTY → BUSY on issue → READY on matching writeback → EMPTY on commit or flush.
- Head and tail pointers, each `$clog2(ROB_SIZE)` bits, wrap modulo `ROB_SIZE`. A `count` register ranges 0..`ROB_SIZE`.
- **Issue:** accepted when `issue_valid && !rob_full && rdy_in`.
  - The entry at `tail` becomes BUSY and stores type, rd and prediction.
  - `tail` advances and `count` increments.
  - If `issue_valid` is high while full, the issue is dropped; the decoder must hold its instruction.
- **Writeback:** if the entry at `wb_tag-1` is BUSY, it stores value, taken and target, then becomes READY. A writeback to an EMPTY or READY entry, or with tag 0, is ignored.
- **Commit:** if the head entry is READY, it retires.
  - Outputs registered: `commit_valid` = 1 and all `commit_*` fields loaded from the head entry.
  - The head entry becomes EMPTY, `head` advances and `count` decrements. At most one commit per cycle.
- **Mispredict:**
  - Condition: a committing branch has stored taken ≠ predicted, or a committing jl.
  - Action: `flush_out` = 1 and `flush_pc` = stored target, in the same registered update as the commit pulse.
  - The same edge clears every entry to EMPTY and sets `head` = `tail` = `count` = 0.
  - Issue and writeback presented on that edge are discarded.
- **Simultaneous issue and commit:** when not full, `count` is unchanged and both pointers advance.
- **Full with commit on the same edge:** the issue is still rejected, because `rob_full` is decided on the pre-edge `count`.
- **Writeback to the head entry:** may commit on the following edge, never on the same edge.

## Timing
- Reset (asynchronous assert, values held while low):
  - `commit_valid`, `flush_out` = 0.
  - `commit_tag`, `commit_dest_type`, `commit_rd`, `commit_value`, `flush_pc` = 0.
  - All entries EMPTY; `head`, `tail`, `count` = 0; `rob_full` = 0; `issue_tag` = 1.
- Issue at edge N makes the entry visible to queries from cycle N+1.
- Writeback at edge N gives READY from N+1. The earliest commit is edge N+1, so `commit_valid` is high during cycle N+1..N+2.
- `commit_valid` and `flush_out` are single-cycle pulses and return to 0 on the next edge with no commit.
- `rdy_in` low: no state changes, and `commit_valid` and `flush_out` are driven 0 on that edge.
- A reset asserted mid-operation empties the buffer immediately and asynchronously; no pending commit is emitted.

## Configuration
- `ROB_WB_BYPASS_EN`
  - Defined: query ports also match the same-cycle writeback. If `wb_valid && wb_tag == queryN_tag` and the entry is BUSY, then `queryN_ready` = 1 and `queryN_value` = `wb_value`.
  - Undefined: queries see registered entry state only, so a result becomes visible one cycle after its writeback.

## Test plan
- **Fill/drain:** with `ROB_SIZE`=4, issue 4 type-1 instructions.
  - Required: `rob_full` = 1 and a fifth issue is dropped.
  - Write back tags 4,3,2,1 in that order. Required: commits appear for tags 1,2,3,4 on consecutive cycles, in order.
- **Wrap-around:** issue and commit 10 instructions with `ROB_SIZE`=4. Required: `issue_tag` cycles 1,2,3,4,1,…; the values committed match the values written back.
- **Mispredict:** issue a branch predicted not-taken, then two reg instructions; write back the branch with taken=1 and target 0x100.
  - Required: `commit_valid` and `flush_out` = 1, `flush_pc` = 0x100.
  - Required on the next cycle: `count` = 0 and `issue_tag` = 1.
- **Simultaneous events while full:** present a commit and an issue on the same edge. Required: the issue is rejected, and on the next edge the issue is accepted.
- **Bypass:** query tag 2 in the same cycle as `wb_tag` = 2 with value 0xDEAD.
  - With `ROB_WB_BYPASS_EN` defined: `query1_ready` = 1 and the value is 0xDEAD.
  - Without it: `query1_ready` = 0 in that cycle and 1 in the next.
- **Reset mid-stream:** drop `rst_in` with 3 entries BUSY and one READY. Required: all outputs go to 0 immediately, and no commit occurs after release.
